// File: rtl/tcp_mem_bram_responder_if.sv
// Command/data/status bus between the TCP stack memory initiator and its memory responder.
// The slave modport is the responder side; the master modport is the initiator side.
interface tcp_mem_bram_responder_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LEN_WIDTH  = 23
);
  localparam int unsigned KW = DATA_WIDTH / 8;

  logic                  s_axis_write_cmd_valid;
  logic                  s_axis_write_cmd_ready;
  logic [31:0]           s_axis_write_cmd_address;
  logic [LEN_WIDTH-1:0]  s_axis_write_cmd_length;
  logic                  s_axis_write_data_valid;
  logic                  s_axis_write_data_ready;
  logic                  s_axis_write_data_last;
  logic [DATA_WIDTH-1:0] s_axis_write_data_data;
  logic [KW-1:0]         s_axis_write_data_keep;
  logic                  m_axis_write_sts_valid;
  logic                  m_axis_write_sts_ready;
  logic [7:0]            m_axis_write_sts_data;
  logic                  s_axis_read_cmd_valid;
  logic                  s_axis_read_cmd_ready;
  logic [31:0]           s_axis_read_cmd_address;
  logic [LEN_WIDTH-1:0]  s_axis_read_cmd_length;
  logic                  m_axis_read_data_valid;
  logic                  m_axis_read_data_ready;
  logic                  m_axis_read_data_last;
  logic [DATA_WIDTH-1:0] m_axis_read_data_data;
  logic [KW-1:0]         m_axis_read_data_keep;
  logic                  m_axis_read_sts_valid;
  logic                  m_axis_read_sts_ready;
  logic [7:0]            m_axis_read_sts_data;

  modport slave (
    input  s_axis_write_cmd_valid, s_axis_write_cmd_address, s_axis_write_cmd_length,
    output s_axis_write_cmd_ready,
    input  s_axis_write_data_valid, s_axis_write_data_last, s_axis_write_data_data,
           s_axis_write_data_keep,
    output s_axis_write_data_ready,
    output m_axis_write_sts_valid, m_axis_write_sts_data,
    input  m_axis_write_sts_ready,
    input  s_axis_read_cmd_valid, s_axis_read_cmd_address, s_axis_read_cmd_length,
    output s_axis_read_cmd_ready,
    output m_axis_read_data_valid, m_axis_read_data_last, m_axis_read_data_data,
           m_axis_read_data_keep,
    input  m_axis_read_data_ready,
    output m_axis_read_sts_valid, m_axis_read_sts_data,
    input  m_axis_read_sts_ready
  );

  modport master (
    output s_axis_write_cmd_valid, s_axis_write_cmd_address, s_axis_write_cmd_length,
    input  s_axis_write_cmd_ready,
    output s_axis_write_data_valid, s_axis_write_data_last, s_axis_write_data_data,
           s_axis_write_data_keep,
    input  s_axis_write_data_ready,
    input  m_axis_write_sts_valid, m_axis_write_sts_data,
    output m_axis_write_sts_ready,
    output s_axis_read_cmd_valid, s_axis_read_cmd_address, s_axis_read_cmd_length,
    input  s_axis_read_cmd_ready,
    input  m_axis_read_data_valid, m_axis_read_data_last, m_axis_read_data_data,
           m_axis_read_data_keep,
    output m_axis_read_data_ready,
    input  m_axis_read_sts_valid, m_axis_read_sts_data,
    output m_axis_read_sts_ready
  );
endinterface

// File: rtl/tcp_mem_bram_responder.sv
// BRAM-backed memory responder: independent write and read burst engines on a
// dual-port BRAM, returning datamover-style status bytes.
module tcp_mem_bram_responder #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned LEN_WIDTH   = 23,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                     net_clk,
  input  logic                     net_areset,
  tcp_mem_bram_responder_if.slave  bus
);
  localparam int unsigned KW   = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(KW);
  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned BW   = LEN_WIDTH - OFFS + 1;

  localparam logic [7:0] STS_OKAY   = 8'h80;
  localparam logic [7:0] STS_SLVERR = 8'h40;
  localparam logic [7:0] STS_DECERR = 8'h20;
  localparam logic [7:0] STS_INTERR = 8'h10;

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_STS = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd1, R_STS = 2'd2;

  function automatic logic [BW-1:0] beats_of(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] t;
    t = {1'b0, len} + (LEN_WIDTH+1)'(KW - 1);
    return BW'(t >> OFFS);
  endfunction

  // Range check is done at full width so an out-of-range burst can never wrap.
  function automatic logic [7:0] status_of(input logic [31:0] addr, input logic [LEN_WIDTH-1:0] len);
    if (len == '0)                                                       return STS_INTERR;
    if (addr[OFFS-1:0] != '0)                                            return STS_SLVERR;
    if (33'(addr >> OFFS) + 33'(beats_of(len)) > 33'(DEPTH_WORDS))       return STS_DECERR;
    return STS_OKAY;
  endfunction

  function automatic logic [KW-1:0] tail_keep(input logic [LEN_WIDTH-1:0] len);
    logic [KW-1:0] k;
    for (int unsigned b = 0; b < KW; b++)
      k[b] = (len[OFFS-1:0] == '0) || (b < 32'(len[OFFS-1:0]));
    return k;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------- write engine ----------------
  logic [1:0]    w_state_q, w_state_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [BW-1:0] w_left_q, w_left_d;
  logic [7:0]    w_sts_q, w_sts_d;
  logic          w_cmd_rdy_q, w_data_rdy_q, w_sts_vld_q;
  logic          w_cmd_hs_c, w_beat_c, w_we_c;

  assign w_cmd_hs_c = bus.s_axis_write_cmd_valid & w_cmd_rdy_q;
  assign w_beat_c   = bus.s_axis_write_data_valid & w_data_rdy_q;
  assign w_we_c     = w_beat_c & (w_state_q == W_DATA) & (w_sts_q == STS_OKAY);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_left_d  = w_left_q;
    w_sts_d   = w_sts_q;
    case (w_state_q)
      W_IDLE: if (w_cmd_hs_c) begin
        w_sts_d   = status_of(bus.s_axis_write_cmd_address, bus.s_axis_write_cmd_length);
        w_addr_d  = AW'(bus.s_axis_write_cmd_address >> OFFS);
        w_left_d  = beats_of(bus.s_axis_write_cmd_length);
        w_state_d = (w_sts_d == STS_INTERR) ? W_STS : W_DATA;
      end
      W_DATA: if (w_beat_c) begin
        w_addr_d = w_addr_q + AW'(1);
        w_left_d = w_left_q - BW'(1);
        if ((w_left_q == BW'(1)) || bus.s_axis_write_data_last) begin
          if (!((w_left_q == BW'(1)) && bus.s_axis_write_data_last)) w_sts_d = STS_INTERR;
          w_state_d = W_STS;
        end
      end
      W_STS: if (w_sts_vld_q && bus.m_axis_write_sts_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      w_state_q    <= W_IDLE;
      w_addr_q     <= '0;
      w_left_q     <= '0;
      w_sts_q      <= '0;
      w_cmd_rdy_q  <= 1'b0;
      w_data_rdy_q <= 1'b0;
      w_sts_vld_q  <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      w_addr_q     <= w_addr_d;
      w_left_q     <= w_left_d;
      w_sts_q      <= w_sts_d;
      w_cmd_rdy_q  <= (w_state_d == W_IDLE);
      w_data_rdy_q <= (w_state_d == W_DATA);
      w_sts_vld_q  <= (w_state_d == W_STS);
    end
  end

  // ---------------- read engine ----------------
  logic [1:0]            r_state_q, r_state_d;
  logic [7:0]            r_sts_q, r_sts_d;
  logic [AW-1:0]         r_addr_q, r_addr_d;
  logic [BW-1:0]         r_left_q, r_left_d, r_beats_c;
  logic [KW-1:0]         r_tkeep_q, r_tkeep_d;
  logic                  r_cmd_rdy_q, r_sts_vld_q;
  logic                  r_cmd_hs_c, r_pop_c;
  logic [1:0]            r_occ_c;
  logic                  rd_en_c, rd_last_c;
  logic [AW-1:0]         rd_addr_c;
  logic [KW-1:0]         rd_keep_c;
  logic                  rd_vld_q, rd_last_q;
  logic [KW-1:0]         rd_keep_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  out_vld_q, out_last_q, skd_vld_q, skd_last_q;
  logic [KW-1:0]         out_keep_q, skd_keep_q;
  logic [DATA_WIDTH-1:0] out_data_q, skd_data_q;

  assign r_cmd_hs_c = bus.s_axis_read_cmd_valid & r_cmd_rdy_q;
  assign r_pop_c    = out_vld_q & bus.m_axis_read_data_ready;
  // Beats held in the skid pair plus the one in the BRAM pipe never exceed two.
  assign r_occ_c    = 2'(out_vld_q) + 2'(skd_vld_q) + 2'(rd_vld_q) - 2'(r_pop_c);
  assign r_beats_c  = beats_of(bus.s_axis_read_cmd_length);

  always_comb begin
    r_state_d = r_state_q;
    r_sts_d   = r_sts_q;
    r_addr_d  = r_addr_q;
    r_left_d  = r_left_q;
    r_tkeep_d = r_tkeep_q;
    rd_en_c   = 1'b0;
    rd_addr_c = r_addr_q;
    rd_last_c = 1'b0;
    rd_keep_c = '1;
    case (r_state_q)
      // The first BRAM read is launched on the command edge to reach cycle-2 data.
      R_IDLE: if (r_cmd_hs_c) begin
        r_sts_d   = status_of(bus.s_axis_read_cmd_address, bus.s_axis_read_cmd_length);
        r_tkeep_d = tail_keep(bus.s_axis_read_cmd_length);
        if (r_sts_d == STS_OKAY) begin
          rd_en_c   = 1'b1;
          rd_addr_c = AW'(bus.s_axis_read_cmd_address >> OFFS);
          rd_last_c = (r_beats_c == BW'(1));
          rd_keep_c = rd_last_c ? r_tkeep_d : '1;
          r_addr_d  = rd_addr_c + AW'(1);
          r_left_d  = r_beats_c - BW'(1);
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_STS;
        end
      end
      R_DATA: begin
        if ((r_left_q != '0) && (r_occ_c < 2'd2)) begin
          rd_en_c   = 1'b1;
          rd_last_c = (r_left_q == BW'(1));
          rd_keep_c = rd_last_c ? r_tkeep_q : '1;
          r_addr_d  = r_addr_q + AW'(1);
          r_left_d  = r_left_q - BW'(1);
        end
        if (r_pop_c && out_last_q) r_state_d = R_STS;
      end
      R_STS: if (r_sts_vld_q && bus.m_axis_read_sts_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_state_q   <= R_IDLE;
      r_sts_q     <= '0;
      r_addr_q    <= '0;
      r_left_q    <= '0;
      r_tkeep_q   <= '0;
      r_cmd_rdy_q <= 1'b0;
      r_sts_vld_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_keep_q   <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      out_data_q  <= '0;
      skd_vld_q   <= 1'b0;
      skd_last_q  <= 1'b0;
      skd_keep_q  <= '0;
      skd_data_q  <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_sts_q     <= r_sts_d;
      r_addr_q    <= r_addr_d;
      r_left_q    <= r_left_d;
      r_tkeep_q   <= r_tkeep_d;
      r_cmd_rdy_q <= (r_state_d == R_IDLE);
      r_sts_vld_q <= (r_state_d == R_STS);
      rd_vld_q    <= rd_en_c;
      rd_last_q   <= rd_last_c;
      rd_keep_q   <= rd_keep_c;
      if (!out_vld_q || r_pop_c) begin
        if (skd_vld_q) begin
          out_vld_q  <= 1'b1;
          out_data_q <= skd_data_q;
          out_keep_q <= skd_keep_q;
          out_last_q <= skd_last_q;
          skd_vld_q  <= rd_vld_q;
          skd_data_q <= rd_data_q;
          skd_keep_q <= rd_keep_q;
          skd_last_q <= rd_last_q;
        end else begin
          out_vld_q  <= rd_vld_q;
          out_data_q <= rd_data_q;
          out_keep_q <= rd_keep_q;
          out_last_q <= rd_last_q;
        end
      end else if (rd_vld_q) begin
        skd_vld_q  <= 1'b1;
        skd_data_q <= rd_data_q;
        skd_keep_q <= rd_keep_q;
        skd_last_q <= rd_last_q;
      end
    end
  end

  // BRAM: byte-enabled write port, registered read port; same-word collision reads old data.
  always_ff @(posedge net_clk) begin
    if (w_we_c)
      for (int unsigned b = 0; b < KW; b++)
        if (bus.s_axis_write_data_keep[b]) mem[w_addr_q][b*8 +: 8] <= bus.s_axis_write_data_data[b*8 +: 8];
    if (rd_en_c) rd_data_q <= mem[rd_addr_c];
  end

  assign bus.s_axis_write_cmd_ready  = w_cmd_rdy_q;
  assign bus.s_axis_write_data_ready = w_data_rdy_q;
  assign bus.m_axis_write_sts_valid  = w_sts_vld_q;
  assign bus.m_axis_write_sts_data   = w_sts_q;
  assign bus.s_axis_read_cmd_ready   = r_cmd_rdy_q;
  assign bus.m_axis_read_data_valid  = out_vld_q;
  assign bus.m_axis_read_data_data   = out_data_q;
  assign bus.m_axis_read_data_keep   = out_keep_q;
  assign bus.m_axis_read_data_last   = out_last_q;
  assign bus.m_axis_read_sts_valid   = r_sts_vld_q;
  assign bus.m_axis_read_sts_data    = r_sts_q;
endmodule

// File: tb/tb_tcp_mem_bram_responder.sv
// Directed scoreboard bench for tcp_mem_bram_responder: writes, reads, error statuses,
// back-pressure, concurrent engines and mid-burst reset.
module tb_tcp_mem_bram_responder;
  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  beat_t      rdq[$];
  logic [7:0] rsq[$];
  logic [7:0] wsq[$];

  tcp_mem_bram_responder_if #(.DATA_WIDTH(512), .LEN_WIDTH(23)) bus ();

  tcp_mem_bram_responder #(.DATA_WIDTH(512), .LEN_WIDTH(23), .DEPTH_WORDS(1024)) dut (
    .net_clk    (clk),
    .net_areset (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rnd();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] kmask(input logic [63:0] k);
    logic [511:0] m;
    for (int b = 0; b < 64; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  // Read data monitor: scoreboard compare plus stability of a stalled beat.
  logic         prev_stall = 1'b0;
  logic [511:0] prev_d;
  logic [63:0]  prev_k;
  logic         prev_l;
  logic         had_last = 1'b0;
  int           last_cyc = 0;
  always @(negedge clk) begin
    beat_t e;
    if (prev_stall) begin
      chk("rd_hold_valid", bus.m_axis_read_data_valid, 1'b1);
      chk("rd_hold_data",  bus.m_axis_read_data_data, prev_d);
      chk("rd_hold_keep",  bus.m_axis_read_data_keep, prev_k);
      chk("rd_hold_last",  bus.m_axis_read_data_last, prev_l);
    end
    prev_stall = bus.m_axis_read_data_valid && !bus.m_axis_read_data_ready;
    prev_d = bus.m_axis_read_data_data;
    prev_k = bus.m_axis_read_data_keep;
    prev_l = bus.m_axis_read_data_last;
    if (bus.m_axis_read_data_valid && bus.m_axis_read_data_ready) begin
      chk("rd_beat_expected", rdq.size() != 0, 1'b1);
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        chk("rd_keep", bus.m_axis_read_data_keep, e.k);
        chk("rd_last", bus.m_axis_read_data_last, e.l);
        chk("rd_data", bus.m_axis_read_data_data & kmask(e.k), e.d & kmask(e.k));
      end
      if (bus.m_axis_read_data_last) begin
        had_last = 1'b1;
        last_cyc = cyc;
      end
    end
    if (bus.m_axis_read_sts_valid && bus.m_axis_read_sts_ready) begin
      chk("rsts_expected", rsq.size() != 0, 1'b1);
      if (rsq.size() != 0) chk("rsts_data", bus.m_axis_read_sts_data, rsq.pop_front());
      if (had_last) chk("rsts_gap", 32'(cyc - last_cyc), 32'd1);
      had_last = 1'b0;
    end
    if (bus.m_axis_write_sts_valid && bus.m_axis_write_sts_ready) begin
      chk("wsts_expected", wsq.size() != 0, 1'b1);
      if (wsq.size() != 0) chk("wsts_data", bus.m_axis_write_sts_data, wsq.pop_front());
    end
  end

  task automatic wr_cmd(input logic [31:0] a, input logic [22:0] len);
    int n = 0;
    bus.s_axis_write_cmd_address = a;
    bus.s_axis_write_cmd_length  = len;
    bus.s_axis_write_cmd_valid   = 1'b1;
    while (!bus.s_axis_write_cmd_ready && n < 100) begin step(); n++; end
    chk("wr_cmd_ready", bus.s_axis_write_cmd_ready, 1'b1);
    step();
    bus.s_axis_write_cmd_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int n = 0;
    bus.s_axis_write_data_data  = d;
    bus.s_axis_write_data_keep  = k;
    bus.s_axis_write_data_last  = l;
    bus.s_axis_write_data_valid = 1'b1;
    while (!bus.s_axis_write_data_ready && n < 100) begin step(); n++; end
    chk("wr_data_ready", bus.s_axis_write_data_ready, 1'b1);
    step();
    bus.s_axis_write_data_valid = 1'b0;
  endtask

  task automatic rd_cmd(input logic [31:0] a, input logic [22:0] len);
    int n = 0;
    bus.s_axis_read_cmd_address = a;
    bus.s_axis_read_cmd_length  = len;
    bus.s_axis_read_cmd_valid   = 1'b1;
    while (!bus.s_axis_read_cmd_ready && n < 100) begin step(); n++; end
    chk("rd_cmd_ready", bus.s_axis_read_cmd_ready, 1'b1);
    step();
    bus.s_axis_read_cmd_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [511:0] d, input logic [63:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    rdq.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while ((rdq.size() + rsq.size() + wsq.size()) != 0 && n < 300) begin step(); n++; end
    chk("drain", 32'(rdq.size() + rsq.size() + wsq.size()), 32'd0);
  endtask

  logic [511:0] va, vb, vc, vd, ve, vf, vg, vh, vk, vm;
  logic [511:0] p [4];
  localparam logic [63:0] ONES = '1;

  initial begin
    va = rnd(); vb = rnd(); vc = rnd(); vd = rnd(); ve = rnd();
    vf = rnd(); vg = rnd(); vh = rnd(); vk = rnd(); vm = rnd();
    for (int i = 0; i < 4; i++) p[i] = rnd();
    bus.s_axis_write_cmd_valid = 0; bus.s_axis_write_cmd_address = 0; bus.s_axis_write_cmd_length = 0;
    bus.s_axis_write_data_valid = 0; bus.s_axis_write_data_last = 0;
    bus.s_axis_write_data_data = 0; bus.s_axis_write_data_keep = 0;
    bus.m_axis_write_sts_ready = 1;
    bus.s_axis_read_cmd_valid = 0; bus.s_axis_read_cmd_address = 0; bus.s_axis_read_cmd_length = 0;
    bus.m_axis_read_data_ready = 1;
    bus.m_axis_read_sts_ready = 1;

    repeat (3) step();
    chk("rst_wcmd_ready", bus.s_axis_write_cmd_ready, 1'b0);
    chk("rst_rcmd_ready", bus.s_axis_read_cmd_ready, 1'b0);
    chk("rst_wdata_ready", bus.s_axis_write_data_ready, 1'b0);
    chk("rst_rdata_valid", bus.m_axis_read_data_valid, 1'b0);
    chk("rst_wsts_valid", bus.m_axis_write_sts_valid, 1'b0);
    chk("rst_rsts_valid", bus.m_axis_read_sts_valid, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_wcmd_ready", bus.s_axis_write_cmd_ready, 1'b1);
    chk("post_rst_rcmd_ready", bus.s_axis_read_cmd_ready, 1'b1);

    // 128 B write then read back
    wsq.push_back(8'h80);
    wr_cmd(32'h40, 23'd128);
    wr_beat(va, ONES, 1'b0);
    wr_beat(vb, ONES, 1'b1);
    chk("wsts_next_cycle", bus.m_axis_write_sts_valid, 1'b1);
    drain();
    push_rd(va, ONES, 1'b0); push_rd(vb, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h40, 23'd128);
    chk("rd_cycle1_no_valid", bus.m_axis_read_data_valid, 1'b0);
    step();
    chk("rd_cycle2_valid", bus.m_axis_read_data_valid, 1'b1);
    drain();

    // 100 B read: partial keep on the tail beat
    push_rd(va, ONES, 1'b0); push_rd(vb, 64'h0000_000F_FFFF_FFFF, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h40, 23'd100);
    drain();

    // misaligned write is consumed and discarded
    wsq.push_back(8'h40);
    wr_cmd(32'h41, 23'd64);
    wr_beat(vc, ONES, 1'b1);
    drain();
    push_rd(va, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h40, 23'd64);
    drain();

    // out-of-range write must not alias onto word 0
    wsq.push_back(8'h80);
    wr_cmd(32'h0, 23'd64);
    wr_beat(ve, ONES, 1'b1);
    drain();
    wsq.push_back(8'h20);
    wr_cmd(32'h10000, 23'd64);
    wr_beat(vd, ONES, 1'b1);
    drain();
    push_rd(ve, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h0, 23'd64);
    drain();

    // last word of BRAM is in range; one past it is DECERR; misaligned read is SLVERR
    wsq.push_back(8'h80);
    wr_cmd(32'hFFC0, 23'd64);
    wr_beat(vk, ONES, 1'b1);
    drain();
    push_rd(vk, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'hFFC0, 23'd64);
    drain();
    rsq.push_back(8'h20);
    rd_cmd(32'hFFC0, 23'd128);
    chk("rd_decerr_no_data", bus.m_axis_read_data_valid, 1'b0);
    drain();
    rsq.push_back(8'h40);
    rd_cmd(32'h41, 23'd64);
    drain();

    // early last: INTERR, excess beat waits for the next command
    wsq.push_back(8'h10);
    wr_cmd(32'h100, 23'd192);
    wr_beat(vf, ONES, 1'b0);
    wr_beat(vg, ONES, 1'b1);
    chk("wsts_interr_next_cycle", bus.m_axis_write_sts_valid, 1'b1);
    drain();
    bus.s_axis_write_data_data = vh; bus.s_axis_write_data_keep = ONES;
    bus.s_axis_write_data_last = 1'b1; bus.s_axis_write_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wdata_held_off", bus.s_axis_write_data_ready, 1'b0);
    end
    wsq.push_back(8'h80);
    wr_cmd(32'h140, 23'd64);
    wr_beat(vh, ONES, 1'b1);
    drain();
    push_rd(vh, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h140, 23'd64);
    drain();

    // zero-length read: INTERR status in cycle 1, no data
    rsq.push_back(8'h10);
    rd_cmd(32'h40, 23'd0);
    chk("rd_len0_sts_cycle1", bus.m_axis_read_sts_valid, 1'b1);
    chk("rd_len0_no_data", bus.m_axis_read_data_valid, 1'b0);
    drain();

    // 4-beat read under toggling ready, concurrent with a write elsewhere
    wsq.push_back(8'h80);
    wr_cmd(32'h200, 23'd256);
    for (int i = 0; i < 4; i++) wr_beat(p[i], ONES, i == 3);
    drain();
    for (int i = 0; i < 4; i++) push_rd(p[i], ONES, i == 3);
    rsq.push_back(8'h80);
    wsq.push_back(8'h80);
    fork
      rd_cmd(32'h200, 23'd256);
      begin wr_cmd(32'h400, 23'd64); wr_beat(vm, ONES, 1'b1); end
      begin
        for (int i = 0; i < 16; i++) begin step(); bus.m_axis_read_data_ready = ~bus.m_axis_read_data_ready; end
        bus.m_axis_read_data_ready = 1'b1;
      end
    join
    drain();
    push_rd(vm, ONES, 1'b1); rsq.push_back(8'h80);
    rd_cmd(32'h400, 23'd64);
    drain();

    // reset during beat 2 of a read burst
    push_rd(p[0], ONES, 1'b0);
    rd_cmd(32'h200, 23'd256);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata_valid", bus.m_axis_read_data_valid, 1'b0);
    chk("mid_rst_rcmd_ready", bus.s_axis_read_cmd_ready, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("after_rst_rcmd_ready", bus.s_axis_read_cmd_ready, 1'b1);
    repeat (10) step();
    chk("after_rst_no_stale", 32'(rdq.size() + rsq.size() + wsq.size()), 32'd0);
    chk("after_rst_rsts_idle", bus.m_axis_read_sts_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
